output_writeback: RTL and testbench

//  Downstream drain stage of the TPU systolic array, feeding GBUFF_OUT.
//  - Accepts one 4-lane result row per handshake beat (one row of a 4x4 output tile).
//  - Packs each beat into one 32-bit GBUFF_OUT word at the row-major address the checker expects.
//  - Masks rows beyond m and zeroes columns beyond n.
//  - Pulses done after the last write.

---
 rtl/output_writeback_pkg.sv | 30 +++
 rtl/output_writeback_addr_gen.sv | 71 +++++++
 rtl/output_writeback.sv | 164 ++++++++++++++++
 tb/tb_output_writeback.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/output_writeback_pkg.sv
// Shared definitions for the GBUFF_OUT writeback stage: widths, FSM encoding and
// the tile geometry helpers used by the controller and by benches.
package output_writeback_pkg;

    localparam int DATA_W = 8;
    localparam int LANES  = 4;
    localparam int ADDR_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } wb_state_e;

    // Number of 4-column tiles needed to cover n output columns.
    function automatic logic [1:0] row_offset(input logic [3:0] n);
        if (n >= 4'd9) begin
            return 2'd3;
        end else if (n >= 4'd5) begin
            return 2'd2;
        end else begin
            return 2'd1;
        end
    endfunction

    function automatic logic [3:0] clamp_dim(input logic [3:0] v);
        return (v > 4'd12) ? 4'd12 : v;
    endfunction

endpackage

// File: rtl/output_writeback_addr_gen.sv
// Beat counters for the drain walk (tile_row > tile_col > r) and the resulting
// row-major GBUFF_OUT address, last-beat flag and row mask.
module wb_addr_gen
    import output_writeback_pkg::*;
#(
    parameter int ADDR_W_P = ADDR_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                advance,
    input  logic [1:0]          row_offset_i,
    input  logic [1:0]          tiles_r_i,
    input  logic [3:0]          m_i,
    output logic [1:0]          tile_col,
    output logic [ADDR_W_P-1:0] wr_addr,
    output logic                last,
    output logic                row_valid
);

    logic [1:0] r_q, r_d;
    logic [1:0] tc_q, tc_d;
    logic [1:0] tr_q, tr_d;

    // Counter advance: r wraps into tile_col, tile_col wraps into tile_row.
    always_comb begin
        r_d  = r_q;
        tc_d = tc_q;
        tr_d = tr_q;
        if (clear || (advance && last)) begin
            r_d  = 2'd0;
            tc_d = 2'd0;
            tr_d = 2'd0;
        end else if (advance) begin
            if (r_q == 2'd3) begin
                r_d = 2'd0;
                if (tc_q == (row_offset_i - 2'd1)) begin
                    tc_d = 2'd0;
                    tr_d = tr_q + 2'd1;
                end else begin
                    tc_d = tc_q + 2'd1;
                end
            end else begin
                r_d = r_q + 2'd1;
            end
        end else begin
            r_d = r_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q  <= 2'd0;
            tc_q <= 2'd0;
            tr_q <= 2'd0;
        end else begin
            r_q  <= r_d;
            tc_q <= tc_d;
            tr_q <= tr_d;
        end
    end

    // grow = tile_row*4 + r is simply the concatenation {tile_row, r}.
    assign tile_col  = tc_q;
    assign wr_addr   = ADDR_W_P'({tr_q, r_q}) * ADDR_W_P'(row_offset_i) + ADDR_W_P'(tc_q);
    assign row_valid = ({tr_q, r_q} < m_i);
    assign last      = (r_q == 2'd3) && (tc_q == (row_offset_i - 2'd1))
                    && (tr_q == (tiles_r_i - 2'd1));

endmodule

// File: rtl/output_writeback.sv
// Drain stage of the systolic array: packs 4-lane result rows into GBUFF_OUT words,
// masking rows beyond m and zeroing columns beyond n, then pulses done.
module output_writeback
    import output_writeback_pkg::*;
#(
    parameter int DATA_W_P = DATA_W,
    parameter int LANES_P  = LANES,
    parameter int ADDR_W_P = ADDR_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [3:0]                   m,
    input  logic [3:0]                   n,
    input  logic                         in_valid,
    input  logic [LANES_P*DATA_W_P-1:0]  in_data,
    output logic                         in_ready,
    output logic                         wr_en,
    output logic [ADDR_W_P-1:0]          wr_addr,
    output logic [LANES_P*DATA_W_P-1:0]  wr_data,
    output logic                         done
);

    wb_state_e                    state_q, state_d;
    logic [3:0]                   m_q, m_d, n_q, n_d;
    logic [1:0]                   ro_q, ro_d, tiles_q, tiles_d;
    logic                         in_ready_q, in_ready_d;
    logic                         wr_en_q, wr_en_d;
    logic [ADDR_W_P-1:0]          wr_addr_q, wr_addr_d;
    logic [LANES_P*DATA_W_P-1:0]  wr_data_q, wr_data_d;
    logic                         done_q, done_d;

    logic                         gen_clear_s, advance_s, last_s, row_valid_s;
    logic [1:0]                   tile_col_s;
    logic [ADDR_W_P-1:0]          gen_addr_s;
    logic [LANES_P*DATA_W_P-1:0]  masked_s;
    logic [3:0]                   m_cl_s, n_cl_s;

    assign m_cl_s    = clamp_dim(m);
    assign n_cl_s    = clamp_dim(n);
    assign advance_s = (state_q == ST_BUSY) && in_valid && in_ready_q;

    wb_addr_gen #(.ADDR_W_P(ADDR_W_P)) u_addr_gen (
        .clk          (clk),
        .rst          (rst),
        .clear        (gen_clear_s),
        .advance      (advance_s),
        .row_offset_i (ro_q),
        .tiles_r_i    (tiles_q),
        .m_i          (m_q),
        .tile_col     (tile_col_s),
        .wr_addr      (gen_addr_s),
        .last         (last_s),
        .row_valid    (row_valid_s)
    );

    // Column mask: lane j holds output column tile_col*4 + j.
    always_comb begin
        logic [3:0] col;
        masked_s = '0;
        for (int j = 0; j < LANES_P; j++) begin
            col = {tile_col_s, 2'b00} + 4'(j);
            if (col < n_q) begin
                masked_s[DATA_W_P*j +: DATA_W_P] = in_data[DATA_W_P*j +: DATA_W_P];
            end else begin
                masked_s[DATA_W_P*j +: DATA_W_P] = '0;
            end
        end
    end

    // Job FSM and next values of the registered write port.
    always_comb begin
        state_d     = state_q;
        m_d         = m_q;
        n_d         = n_q;
        ro_d        = ro_q;
        tiles_d     = tiles_q;
        in_ready_d  = 1'b0;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        done_d      = 1'b0;
        gen_clear_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    m_d         = m_cl_s;
                    n_d         = n_cl_s;
                    ro_d        = row_offset(n_cl_s);
                    tiles_d     = 2'((m_cl_s + 4'd3) >> 2);
                    gen_clear_s = 1'b1;
                    if ((m_cl_s == 4'd0) || (n_cl_s == 4'd0)) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d    = ST_BUSY;
                        in_ready_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (advance_s) begin
                    if (row_valid_s) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = gen_addr_s;
                        wr_data_d = masked_s;
                    end else begin
                        wr_en_d = 1'b0;
                    end
                    if (last_s) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        in_ready_d = 1'b1;
                    end
                end else begin
                    in_ready_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            m_q        <= 4'd0;
            n_q        <= 4'd0;
            ro_q       <= 2'd0;
            tiles_q    <= 2'd0;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            m_q        <= m_d;
            n_q        <= n_d;
            ro_q       <= ro_d;
            tiles_q    <= tiles_d;
            in_ready_q <= in_ready_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            done_q     <= done_d;
        end
    end

    assign in_ready = in_ready_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign done     = done_q;

endmodule

// File: tb/tb_output_writeback.sv
// Randomized bench for output_writeback: a job-level model expands m/n into the
// expected GBUFF_OUT writes and a monitor compares every write against it.
module tb_output_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  m;
    logic [3:0]  n;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic        done;

    output_writeback dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .m        (m),
        .n        (n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .done     (done)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          done_cnt = 0;
    logic [7:0]  exp_addr_q[$];
    logic [31:0] exp_data_q[$];

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Write monitor: every write must match the head of the expected queue.
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (wr_en === 1'b1) begin
            if (exp_addr_q.size() == 0) begin
                chk_eq("unexpected_wr_en", {31'd0, wr_en}, 32'd0);
            end else begin
                chk_eq("wr_addr", {24'd0, wr_addr}, {24'd0, exp_addr_q.pop_front()});
                chk_eq("wr_data", wr_data, exp_data_q.pop_front());
            end
        end
    end

    task automatic chk_idle_outputs(input string tag);
        chk_eq({tag, "_wr_en"},    {31'd0, wr_en},    32'd0);
        chk_eq({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        chk_eq({tag, "_done"},     {31'd0, done},     32'd0);
        chk_eq({tag, "_wr_addr"},  {24'd0, wr_addr},  32'd0);
        chk_eq({tag, "_wr_data"},  wr_data,           32'd0);
    endtask

    // vmode: 0 always valid, 1 valid toggles 1-0-1, 2 random ~60% valid.
    // stop_after >= 0 asserts rst once that many beats have been accepted.
    task automatic run_job(input int mi, input int ni, input int vmode,
                           input bit glitch, input int stop_after);
        int mm, nn, ro, tiles, total, acc, cyc, d0, tr, tc, r, grow, col;
        logic [31:0] exp_word;
        bit last_unmasked;
        mm    = (mi > 12) ? 12 : mi;
        nn    = (ni > 12) ? 12 : ni;
        ro    = (nn + 3) / 4;
        tiles = (mm + 3) / 4;
        total = tiles * ro * 4;
        d0    = done_cnt;
        m     = 4'(mi);
        n     = 4'(ni);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        m     = 4'($urandom);
        n     = 4'($urandom);
        if (mm == 0 || nn == 0) begin
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                chk_eq("empty_job_in_ready", {31'd0, in_ready}, 32'd0);
            end
            chk_eq("empty_job_done_pulses", done_cnt - d0, 32'd1);
            @(posedge clk);
            #1;
            return;
        end
        acc = 0;
        cyc = 0;
        while (acc < total && acc != stop_after && cyc < 2000) begin
            in_data = $urandom;
            case (vmode)
                1:       in_valid = (cyc % 2 == 0);
                2:       in_valid = ($urandom_range(0, 99) < 60);
                default: in_valid = 1'b1;
            endcase
            if (glitch && acc < total - 1) begin
                start = ($urandom_range(0, 3) == 0);
                m     = 4'd1;
                n     = 4'($urandom);
            end
            @(negedge clk);
            if (in_valid && in_ready) begin
                tr   = acc / (ro * 4);
                tc   = (acc / 4) % ro;
                r    = acc % 4;
                grow = tr * 4 + r;
                if (grow < mm) begin
                    exp_word = 32'd0;
                    for (int j = 0; j < 4; j++) begin
                        col = tc * 4 + j;
                        if (col < nn) exp_word[8*j +: 8] = in_data[8*j +: 8];
                    end
                    exp_addr_q.push_back(8'(grow * ro + tc));
                    exp_data_q.push_back(exp_word);
                end
                acc++;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            cyc++;
        end
        in_valid = 1'b0;
        if (stop_after >= 0 && acc == stop_after) begin
            rst = 1'b1;
            @(posedge clk);
            #1;
            chk_idle_outputs("mid_job_reset");
            chk_eq("mid_job_pending", exp_addr_q.size(), 32'd0);
            exp_addr_q.delete();
            exp_data_q.delete();
            rst = 1'b0;
            return;
        end
        chk_eq("beats_accepted", acc, total);
        last_unmasked = ((tiles * 4 - 1) < mm);
        @(negedge clk);
        chk_eq("done_on_last", {31'd0, done}, 32'd1);
        chk_eq("wr_en_with_done", {31'd0, wr_en}, {31'd0, last_unmasked});
        chk_eq("in_ready_after_last", {31'd0, in_ready}, 32'd0);
        repeat (3) @(negedge clk);
        chk_eq("done_pulses", done_cnt - d0, 32'd1);
        chk_eq("writes_outstanding", exp_addr_q.size(), 32'd0);
        exp_addr_q.delete();
        exp_data_q.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        m        = 4'd0;
        n        = 4'd0;
        in_valid = 1'b0;
        in_data  = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk_idle_outputs("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_job(4, 4, 0, 1'b0, -1);
        run_job(5, 6, 0, 1'b0, -1);
        run_job(12, 12, 1, 1'b0, -1);
        run_job(0, 4, 0, 1'b0, -1);
        run_job(8, 8, 0, 1'b0, 3);
        run_job(8, 8, 2, 1'b0, -1);
        run_job(9, 3, 2, 1'b1, -1);
        run_job(15, 14, 2, 1'b0, -1);
        run_job(4, 0, 0, 1'b0, -1);
        run_job(1, 12, 2, 1'b0, -1);
        for (int k = 0; k < 8; k++) begin
            run_job($urandom_range(1, 15), $urandom_range(1, 15), 2, k[0], -1);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
